// File: rtl/mem_arbiter.sv
// Two-port (CPU / video) arbiter onto one asynchronous memory with a fixed strobe length.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise video always wins a tie.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_A,
    input  logic [7:0]  cpu_Do,
    output logic [7:0]  cpu_Di,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_cs_n,
    output logic        cpu_ack,
    input  logic [15:0] vid_A,
    input  logic [7:0]  vid_Do,
    output logic [7:0]  vid_Di,
    input  logic        vid_rd_n,
    input  logic        vid_wr_n,
    input  logic        vid_cs_n,
    output logic        vid_ack,
    output logic [15:0] mem_A,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic [1:0]  state_dbg
);

    // Handshake: a port holds cs_n and rd_n/wr_n low until it sees its one-cycle ack;
    // it must release the strobe (or cs_n) before a second access is started.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       cpu_req, vid_req;
    logic       cpu_served, vid_served;
    logic       cpu_pend, vid_pend;
    logic       grant, pick_vid, pick_wr;
    logic       win_vid, is_write;
    logic       access_end;

    assign cpu_req    = !cpu_cs_n && (!cpu_rd_n || !cpu_wr_n);
    assign vid_req    = !vid_cs_n && (!vid_rd_n || !vid_wr_n);
    assign cpu_pend   = cpu_req && !cpu_served;
    assign vid_pend   = vid_req && !vid_served;
    assign access_end = (state == ACCESS) && (cnt == LAST);
    assign state_dbg  = state;

`ifdef MEM_ARB_RR_EN
    logic last_vid;
    assign pick_vid = vid_pend && (!cpu_pend || !last_vid);
`else
    assign pick_vid = vid_pend;
`endif
    // Both strobes low counts as a write.
    assign pick_wr = pick_vid ? !vid_wr_n : !cpu_wr_n;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_pend || vid_pend) begin
                    state_nxt = ACCESS;
                    grant     = 1'b1;
                end
            end
            ACCESS:  if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            win_vid   <= 1'b0;
            is_write  <= 1'b0;
            mem_A     <= '0;
            mem_wdata <= '0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            cpu_Di    <= '0;
            vid_Di    <= '0;
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_vid  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        win_vid   <= pick_vid;
                        is_write  <= pick_wr;
                        mem_A     <= pick_vid ? vid_A : cpu_A;
                        mem_wdata <= pick_vid ? vid_Do : cpu_Do;
                        mem_ce_n  <= 1'b0;
                        mem_oe_n  <= pick_wr;
                        mem_we_n  <= !pick_wr;
                        cnt       <= '0;
`ifdef MEM_ARB_RR_EN
                        last_vid  <= pick_vid;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == LAST) begin
                        mem_ce_n <= 1'b1;
                        mem_oe_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        if (!is_write) begin
                            if (win_vid) vid_Di <= mem_rdata;
                            else         cpu_Di <= mem_rdata;
                        end
                        cpu_ack <= !win_vid;
                        vid_ack <= win_vid;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    vid_ack <= 1'b0;
                end
                default: begin
                    cpu_ack <= 1'b0;
                    vid_ack <= 1'b0;
                end
            endcase
        end
    end

    // A served flag blocks re-grant of a held strobe until the request drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_served <= 1'b0;
            vid_served <= 1'b0;
        end else begin
            if (!cpu_req)                      cpu_served <= 1'b0;
            else if (access_end && !win_vid)   cpu_served <= 1'b1;
            if (!vid_req)                      vid_served <= 1'b0;
            else if (access_end && win_vid)    vid_served <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT_CYCLES=2); tie expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_A = '0, vid_A = '0;
    logic [7:0]  cpu_Do = '0, vid_Do = '0;
    logic        cpu_rd_n = 1'b1, cpu_wr_n = 1'b1, cpu_cs_n = 1'b1;
    logic        vid_rd_n = 1'b1, vid_wr_n = 1'b1, vid_cs_n = 1'b1;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  cpu_Di, vid_Di, mem_wdata;
    logic        cpu_ack, vid_ack, mem_ce_n, mem_oe_n, mem_we_n;
    logic [15:0] mem_A;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    int ce_cnt, ack_cnt;

    mem_arbiter #(.WAIT_CYCLES(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_A(cpu_A), .cpu_Do(cpu_Do), .cpu_Di(cpu_Di),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_cs_n(cpu_cs_n), .cpu_ack(cpu_ack),
        .vid_A(vid_A), .vid_Do(vid_Do), .vid_Di(vid_Di),
        .vid_rd_n(vid_rd_n), .vid_wr_n(vid_wr_n), .vid_cs_n(vid_cs_n), .vid_ack(vid_ack),
        .mem_A(mem_A), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic count_window(input int n);
        ce_cnt = 0;
        ack_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (!mem_ce_n) ce_cnt++;
            if (cpu_ack) ack_cnt++;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ce", 16'(mem_ce_n), 16'h1);
        check("rst_oe", 16'(mem_oe_n), 16'h1);
        check("rst_we", 16'(mem_we_n), 16'h1);
        check("rst_acks", {14'h0, cpu_ack, vid_ack}, 16'h0);
        check("rst_di", {cpu_Di, vid_Di}, 16'h0);
        check("rst_addr", mem_A, 16'h0);
        reset_n = 1'b1;
        tick();

        // CPU read 0x1234 returning 0xA5
        cpu_A = 16'h1234; mem_rdata = 8'hA5; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
        tick();
        check("rd_ce_k1", 16'(mem_ce_n), 16'h0);
        check("rd_oe_k1", 16'(mem_oe_n), 16'h0);
        check("rd_we_k1", 16'(mem_we_n), 16'h1);
        check("rd_addr", mem_A, 16'h1234);
        tick();
        check("rd_ce_k2", 16'(mem_ce_n), 16'h0);
        check("rd_ack_k2", 16'(cpu_ack), 16'h0);
        tick();
        check("rd_ce_k3", 16'(mem_ce_n), 16'h1);
        check("rd_ack_k3", 16'(cpu_ack), 16'h1);
        check("rd_di", 16'(cpu_Di), 16'h00A5);
        cpu_rd_n = 1'b1; cpu_cs_n = 1'b1;
        tick();
        check("rd_ack_k4", 16'(cpu_ack), 16'h0);
        tick();

        // Held strobe served once; release then reassert gives a second access
        mem_rdata = 8'h11; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
        count_window(10);
        check("hold_ce_cycles", 16'(ce_cnt), 16'd2);
        check("hold_acks", 16'(ack_cnt), 16'd1);
        cpu_rd_n = 1'b1;
        tick(); tick();
        cpu_rd_n = 1'b0; mem_rdata = 8'h22;
        count_window(6);
        check("rehold_ce_cycles", 16'(ce_cnt), 16'd2);
        check("rehold_acks", 16'(ack_cnt), 16'd1);
        check("rehold_di", 16'(cpu_Di), 16'h0022);
        cpu_rd_n = 1'b1; cpu_cs_n = 1'b1;
        tick();

        // Video read to give vid_Di a known value
        vid_A = 16'h0042; mem_rdata = 8'h5A; vid_cs_n = 1'b0; vid_rd_n = 1'b0;
        tick(); tick(); tick();
        check("vrd_ack", 16'(vid_ack), 16'h1);
        check("vrd_di", 16'(vid_Di), 16'h005A);
        vid_rd_n = 1'b1; vid_cs_n = 1'b1;
        tick();

        // Video write with inputs changing mid-access
        vid_A = 16'h8000; vid_Do = 8'h3C; mem_rdata = 8'hEE; vid_cs_n = 1'b0; vid_wr_n = 1'b0;
        tick();
        check("vwr_we_k1", 16'(mem_we_n), 16'h0);
        check("vwr_oe_k1", 16'(mem_oe_n), 16'h1);
        vid_A = 16'h9000; vid_Do = 8'hFF;
        tick();
        check("vwr_addr", mem_A, 16'h8000);
        check("vwr_data", 16'(mem_wdata), 16'h003C);
        check("vwr_we_k2", 16'(mem_we_n), 16'h0);
        tick();
        check("vwr_we_k3", 16'(mem_we_n), 16'h1);
        check("vwr_ack", 16'(vid_ack), 16'h1);
        check("vwr_di_kept", 16'(vid_Di), 16'h005A);
        vid_wr_n = 1'b1; vid_cs_n = 1'b1;
        tick();

        // Request dropped before any grant edge
        #2;
        cpu_A = 16'h0BAD; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
        #3;
        cpu_cs_n = 1'b1; cpu_rd_n = 1'b1;
        count_window(4);
        check("drop_ce_cycles", 16'(ce_cnt), 16'd0);
        check("drop_acks", 16'(ack_cnt), 16'd0);

        // Simultaneous requests straight after reset
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        cpu_A = 16'h0100; vid_A = 16'h0200; mem_rdata = 8'h77;
        cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; vid_cs_n = 1'b0; vid_rd_n = 1'b0;
        tick();
`ifdef MEM_ARB_RR_EN
        check("tie_first", mem_A, 16'h0100);
`else
        check("tie_first", mem_A, 16'h0200);
`endif
        tick(); tick();
`ifdef MEM_ARB_RR_EN
        check("tie_first_ack", {14'h0, cpu_ack, vid_ack}, 16'h2);
`else
        check("tie_first_ack", {14'h0, cpu_ack, vid_ack}, 16'h1);
`endif
        tick();
        check("tie_gap_ce", 16'(mem_ce_n), 16'h1);
        tick();
        check("tie_second_ce", 16'(mem_ce_n), 16'h0);
`ifdef MEM_ARB_RR_EN
        check("tie_second", mem_A, 16'h0200);
`else
        check("tie_second", mem_A, 16'h0100);
`endif
        tick(); tick();
`ifdef MEM_ARB_RR_EN
        check("tie_second_ack", {14'h0, cpu_ack, vid_ack}, 16'h1);
`else
        check("tie_second_ack", {14'h0, cpu_ack, vid_ack}, 16'h2);
`endif
        cpu_cs_n = 1'b1; cpu_rd_n = 1'b1; vid_cs_n = 1'b1; vid_rd_n = 1'b1;
        tick();

        // Reset asserted mid-access
        cpu_A = 16'h4444; mem_rdata = 8'h99; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
        tick();
        check("mid_ce_before", 16'(mem_ce_n), 16'h0);
        reset_n = 1'b0;
        #1;
        check("mid_ce_reset", 16'(mem_ce_n), 16'h1);
        check("mid_oe_reset", 16'(mem_oe_n), 16'h1);
        check("mid_ack_reset", 16'(cpu_ack), 16'h0);
        cpu_cs_n = 1'b1; cpu_rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        count_window(3);
        check("post_rst_acks", 16'(ack_cnt), 16'd0);

        // Normal CPU write after reset release
        cpu_A = 16'h0010; cpu_Do = 8'h77; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
        tick();
        check("post_wr_we", 16'(mem_we_n), 16'h0);
        check("post_wr_addr", mem_A, 16'h0010);
        check("post_wr_data", 16'(mem_wdata), 16'h0077);
        tick(); tick();
        check("post_wr_ack", 16'(cpu_ack), 16'h1);
        check("post_wr_di", 16'(cpu_Di), 16'h0000);
        cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory strobe cycles per access; legal range 1..15.
REQ-002 clock  input  1  core clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_A  input  16  CPU address.
REQ-005 cpu_Do  input  8  CPU write data.
REQ-006 cpu_Di  output  8  CPU read data, registered.
REQ-007 cpu_rd_n  input  1  CPU read strobe, active-low.
REQ-008 cpu_wr_n  input  1  CPU write strobe, active-low.
REQ-009 cpu_cs_n  input  1  CPU chip select, active-low.
REQ-010 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-011 vid_A  input  16  video address.
REQ-012 vid_Do  input  8  video write data.
REQ-013 vid_Di  output  8  video read data, registered.
REQ-014 vid_rd_n  input  1  video read strobe, active-low.
REQ-015 vid_wr_n  input  1  video write strobe, active-low.
REQ-016 vid_cs_n  input  1  video chip select, active-low.
REQ-017 vid_ack  output  1  one-cycle completion pulse to video.
REQ-018 mem_A  output  16  shared memory address, registered.
REQ-019 mem_wdata  output  8  shared memory write data, registered.
REQ-020 mem_rdata  input  8  shared memory read data.
REQ-021 mem_ce_n  output  1  memory enable, active-low, registered.
REQ-022 mem_oe_n  output  1  memory output enable, active-low, registered.
REQ-023 mem_we_n  output  1  memory write enable, active-low, registered.

Function
REQ-024 Port request SHALL be !cs_n & (!rd_n | !wr_n); pending SHALL be request & !served for that port.
REQ-025 States SHALL be IDLE, ACCESS, DONE; IDLE -> ACCESS on any pending port, ACCESS -> DONE after WAIT_CYCLES cycles, DONE -> IDLE unconditionally.
REQ-026 On the IDLE grant edge k the arbiter SHALL latch the winner's A, Do and direction; rd_n and wr_n both low SHALL be a write.
REQ-027 mem_ce_n SHALL be low for exactly cycles k+1..k+WAIT_CYCLES, with mem_oe_n low (read) or mem_we_n low (write) over the same cycles; all strobes high otherwise.
REQ-028 For reads, mem_rdata SHALL be captured on the edge ending the last ACCESS cycle into the winner's Di; Di SHALL hold until the next read by that port; writes SHALL NOT change Di.
REQ-029 Winner's ack SHALL be high only in cycle k+WAIT_CYCLES+1 (DONE); the next grant edge SHALL be no earlier than k+WAIT_CYCLES+2.
REQ-030 Port input changes during ACCESS/DONE SHALL be ignored; the latched values SHALL be used.
REQ-031 served SHALL set with ack and clear on the first cycle that port's request is low, so a held strobe is served exactly once.
REQ-032 A request dropped before its grant SHALL be discarded with no memory cycle and no ack.

Reset
REQ-033 reset_n low SHALL immediately force IDLE, mem_ce_n/oe_n/we_n=1, acks=0, cpu_Di/vid_Di/mem_A/mem_wdata=0, served flags=0, last-grant=video, including mid-access.
REQ-034 First grant SHALL be evaluated on the first rising edge after reset_n is sampled high.

Configuration
REQ-035 With MEM_ARB_RR_EN defined, simultaneous pending SHALL grant the port not granted last (last-grant updates each grant).
REQ-036 Without MEM_ARB_RR_EN, simultaneous pending SHALL always grant video; last-grant register SHALL be absent.

Verification
REQ-037 WAIT_CYCLES=2, CPU read 0x1234, mem_rdata=0xA5 -> mem_ce_n/oe_n low 2 cycles, cpu_Di=0xA5, cpu_ack 1 cycle at k+3.
REQ-038 CPU and video request same edge, macro off -> video served first, CPU granted at k+4; macro on, first tie after reset -> CPU first.
REQ-039 CPU holds rd_n low 10 cycles -> exactly one memory cycle, one cpu_ack; release then reassert -> second access.
REQ-040 Video write 0x8000=0x3C, vid_A changes to 0x9000 mid-access -> mem_A=0x8000, mem_wdata=0x3C, mem_we_n low 2 cycles, vid_Di unchanged.
REQ-041 reset_n low during ACCESS -> strobes high same cycle, no ack, next request after release served normally.
